guess_entry_controller: RTL and testbench

GUESS_ENTRY_CONTROLLER -- requirements
Module: guess_entry_controller

---
 rtl/mastermind_pkg.sv | 33 +++
 rtl/button_debounce.sv | 62 ++++++
 rtl/guess_entry_controller.sv | 174 +++++++++++++++++
 tb/tb_guess_entry_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mastermind_pkg.sv
// Shared types and constants for the Mastermind guess-entry logic.
package mastermind_pkg;

  localparam int unsigned NUM_ROWS   = 4;
  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    StEdit   = 2'd0,
    StCommit = 2'd1,
    StFull   = 2'd2
  } state_e;

  // At most one event is acted on per cycle; this is the winner after priority.
  typedef enum logic [2:0] {
    EvNone  = 3'd0,
    EvNext  = 3'd1,
    EvUp    = 3'd2,
    EvDown  = 3'd3,
    EvLeft  = 3'd4,
    EvRight = 3'd5
  } event_e;

  // Increment a digit, wrapping max_val -> 0.
  function automatic logic [3:0] digit_inc(input logic [3:0] v, input logic [3:0] max_val);
    return (v >= max_val) ? 4'd0 : v + 4'd1;
  endfunction

  // Decrement a digit, wrapping 0 -> max_val.
  function automatic logic [3:0] digit_dec(input logic [3:0] v, input logic [3:0] max_val);
    return (v == 4'd0) ? max_val : v - 4'd1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, counter-based debouncer and rising-edge press detector
// for one raw push-button.
module button_debounce #(
  parameter int unsigned DEB_CYCLES = 400000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Synchronizer chain for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreeing samples; flip the level on the DEB_CYCLES-th one.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/guess_entry_controller.sv
// Button-driven entry of four 4-digit guesses for the Mastermind board.
// Buttons are debounced, reduced to a single prioritised event per cycle and
// applied to the guess rows by a small EDIT/COMMIT/FULL state machine.
module guess_entry_controller
  import mastermind_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 400000,
  parameter int unsigned NUM_SYMBOLS = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_up,
  input  logic            btn_down,
  input  logic            btn_left,
  input  logic            btn_right,
  input  logic            btn_next,
  output logic [3:0][3:0] nums [0:3],
  output logic [1:0]      curr_num,
  output logic [1:0]      curr_digit,
  output logic            guess_valid,
  output logic [1:0]      guess_row,
  output logic            board_full
);

  localparam logic [3:0] MaxSym  = 4'(NUM_SYMBOLS - 1);
  localparam logic [1:0] LastRow = 2'(NUM_ROWS - 1);

  logic press_up, press_down, press_left, press_right, press_next;

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_up),
    .press (press_up)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_down),
    .press (press_down)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_left),
    .press (press_left)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_right),
    .press (press_right)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_next),
    .press (press_next)
  );

  state_e          state_q, state_d;
  event_e          ev;
  logic [NUM_DIGITS-1:0][3:0] nums_q [NUM_ROWS];
  logic [NUM_DIGITS-1:0][3:0] nums_d [NUM_ROWS];
  logic [1:0]      curr_num_q, curr_num_d;
  logic [1:0]      curr_digit_q, curr_digit_d;
  logic            guess_valid_q, guess_valid_d;
  logic [1:0]      guess_row_q, guess_row_d;
  logic            board_full_q, board_full_d;

  // Pick the single highest-priority event; the rest are dropped.
  always_comb begin
    ev = EvNone;
    if (press_next)       ev = EvNext;
    else if (press_up)    ev = EvUp;
    else if (press_down)  ev = EvDown;
    else if (press_left)  ev = EvLeft;
    else if (press_right) ev = EvRight;
  end

  // Next-state, digit edits, cursor movement and registered-output inputs.
  always_comb begin
    state_d      = state_q;
    nums_d       = nums_q;
    curr_num_d   = curr_num_q;
    curr_digit_d = curr_digit_q;
    guess_row_d  = guess_row_q;

    unique case (state_q)
      StEdit: begin
        case (ev)
          EvNext:  state_d = StCommit;
          EvUp:    nums_d[curr_num_q][curr_digit_q] =
                     digit_inc(nums_q[curr_num_q][curr_digit_q], MaxSym);
          EvDown:  nums_d[curr_num_q][curr_digit_q] =
                     digit_dec(nums_q[curr_num_q][curr_digit_q], MaxSym);
          EvLeft:  curr_digit_d = curr_digit_q - 2'd1;
          EvRight: curr_digit_d = curr_digit_q + 2'd1;
          default: ;
        endcase
      end
      StCommit: begin
        // Events during the commit cycle are ignored.
        if (curr_num_q == LastRow) begin
          state_d = StFull;
        end else begin
          curr_num_d   = curr_num_q + 2'd1;
          curr_digit_d = 2'd0;
          state_d      = StEdit;
        end
      end
      StFull: begin
        if (ev == EvNext) begin
          for (int r = 0; r < NUM_ROWS; r++) begin
            nums_d[r] = '0;
          end
          curr_num_d   = 2'd0;
          curr_digit_d = 2'd0;
          state_d      = StEdit;
        end
      end
      default: state_d = StEdit;
    endcase

    // Outputs are registered, so derive them from the state being entered.
    guess_valid_d = (state_d == StCommit);
    if (state_d == StCommit) begin
      guess_row_d = curr_num_q;
    end
    board_full_d = (state_d == StFull);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StEdit;
      curr_num_q    <= 2'd0;
      curr_digit_q  <= 2'd0;
      guess_valid_q <= 1'b0;
      guess_row_q   <= 2'd0;
      board_full_q  <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        nums_q[r] <= '0;
      end
    end else begin
      state_q       <= state_d;
      curr_num_q    <= curr_num_d;
      curr_digit_q  <= curr_digit_d;
      guess_valid_q <= guess_valid_d;
      guess_row_q   <= guess_row_d;
      board_full_q  <= board_full_d;
      for (int r = 0; r < NUM_ROWS; r++) begin
        nums_q[r] <= nums_d[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      nums[r] = nums_q[r];
    end
  end

  assign curr_num    = curr_num_q;
  assign curr_digit  = curr_digit_q;
  assign guess_valid = guess_valid_q;
  assign guess_row   = guess_row_q;
  assign board_full  = board_full_q;

endmodule

// File: tb/tb_guess_entry_controller.sv
// Directed bench for guess_entry_controller with a short debounce window.
module tb_guess_entry_controller;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4:0]      btn = 5'b0;  // 0 up, 1 down, 2 left, 3 right, 4 next
  logic [3:0][3:0] nums [0:3];
  logic [1:0]      curr_num, curr_digit, guess_row;
  logic            guess_valid, board_full;

  int n_checks = 0;
  int n_fail   = 0;
  int gv_count = 0;
  logic [1:0] gv_rows [16];

  guess_entry_controller #(.DEB_CYCLES(4), .NUM_SYMBOLS(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_up      (btn[0]),
    .btn_down    (btn[1]),
    .btn_left    (btn[2]),
    .btn_right   (btn[3]),
    .btn_next    (btn[4]),
    .nums        (nums),
    .curr_num    (curr_num),
    .curr_digit  (curr_digit),
    .guess_valid (guess_valid),
    .guess_row   (guess_row),
    .board_full  (board_full)
  );

  always #5 clk = ~clk;

  // Record every commit pulse; a pulse longer than one cycle is counted twice.
  always @(negedge clk) begin
    if (rst_n && guess_valid) begin
      if (gv_count < 16) gv_rows[gv_count] = guess_row;
      gv_count = gv_count + 1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    cycles(10);
    btn[idx] = 1'b0;
    cycles(10);
  endtask

  task automatic apply_reset();
    btn   = 5'b0;
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_reset();
    int nz;
    apply_reset();
    nz = 0;
    for (int r = 0; r < 4; r++) if (nums[r] !== 16'h0) nz++;
    n_checks++;
    if (nz !== 0) begin
      n_fail++; $display("FAIL reset_nums: %0d nonzero rows, expected 0", nz);
    end
    n_checks++;
    if ({curr_num, curr_digit, guess_row} !== 6'b0) begin
      n_fail++; $display("FAIL reset_cursor: num=%0d digit=%0d row=%0d, expected 0",
                         curr_num, curr_digit, guess_row);
    end
    n_checks++;
    if ({guess_valid, board_full} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: gv=%b full=%b, expected 0 0",
                         guess_valid, board_full);
    end
  endtask

  task automatic test_debounce();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      cycles(2);
    end
    n_checks++;
    if (nums[0][0] !== 4'd0) begin
      n_fail++; $display("FAIL debounce_bounce: nums[0][0]=%0d, expected 0", nums[0][0]);
    end
    btn[0] = 1'b1;
    cycles(10);
    btn[0] = 1'b0;
    cycles(10);
    n_checks++;
    if (nums[0][0] !== 4'd1) begin
      n_fail++; $display("FAIL debounce_press: nums[0][0]=%0d, expected 1", nums[0][0]);
    end
  endtask

  task automatic test_digit_wrap();
    logic [3:0] exp;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      press(0);
      exp = 4'((i + 1) % 6);
      n_checks++;
      if (nums[0][0] !== exp) begin
        n_fail++; $display("FAIL wrap_up_%0d: nums[0][0]=%0d, expected %0d", i, nums[0][0], exp);
      end
    end
    press(1);
    n_checks++;
    if (nums[0][0] !== 4'd5) begin
      n_fail++; $display("FAIL wrap_down: nums[0][0]=%0d, expected 5", nums[0][0]);
    end
    press(1);
    n_checks++;
    if (nums[0][0] !== 4'd4) begin
      n_fail++; $display("FAIL down_plain: nums[0][0]=%0d, expected 4", nums[0][0]);
    end
  endtask

  task automatic test_cursor_wrap();
    int nz;
    apply_reset();
    press(2);
    n_checks++;
    if (curr_digit !== 2'd3) begin
      n_fail++; $display("FAIL cursor_left_wrap: digit=%0d, expected 3", curr_digit);
    end
    press(3);
    n_checks++;
    if (curr_digit !== 2'd0) begin
      n_fail++; $display("FAIL cursor_right_wrap: digit=%0d, expected 0", curr_digit);
    end
    press(0);
    nz = 0;
    for (int r = 0; r < 4; r++)
      for (int d = 0; d < 4; d++)
        if (!(r == 0 && d == 0) && nums[r][d] !== 4'd0) nz++;
    n_checks++;
    if (nums[0][0] !== 4'd1 || nz !== 0) begin
      n_fail++; $display("FAIL cursor_edit: nums[0][0]=%0d others_nonzero=%0d, expected 1 0",
                         nums[0][0], nz);
    end
    press(3);
    press(0);
    n_checks++;
    if (nums[0][1] !== 4'd1 || nums[0][0] !== 4'd1) begin
      n_fail++; $display("FAIL cursor_edit_d1: row0=%h, expected 0011", nums[0]);
    end
  endtask

  task automatic test_commit();
    int base, nz;
    apply_reset();
    base = gv_count;
    press(0);
    press(3);
    press(4);
    n_checks++;
    if (gv_count !== base + 1 || curr_num !== 2'd1 || curr_digit !== 2'd0) begin
      n_fail++; $display("FAIL commit_first: pulses=%0d num=%0d digit=%0d, expected %0d 1 0",
                         gv_count - base, curr_num, curr_digit, 1);
    end
    n_checks++;
    if (nums[0][0] !== 4'd1 || guess_valid !== 1'b0) begin
      n_fail++; $display("FAIL commit_hold: nums[0][0]=%0d gv=%b, expected 1 0",
                         nums[0][0], guess_valid);
    end
    for (int i = 1; i < 4; i++) press(4);
    n_checks++;
    if (gv_count !== base + 4) begin
      n_fail++; $display("FAIL commit_count: pulses=%0d, expected 4", gv_count - base);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (gv_rows[base + i] !== 2'(i)) begin
        n_fail++; $display("FAIL commit_row_%0d: guess_row=%0d, expected %0d",
                           i, gv_rows[base + i], i);
      end
    end
    n_checks++;
    if (board_full !== 1'b1 || curr_num !== 2'd3) begin
      n_fail++; $display("FAIL full_state: full=%b num=%0d, expected 1 3", board_full, curr_num);
    end
    press(0);
    n_checks++;
    if (nums[3][0] !== 4'd0 || board_full !== 1'b1) begin
      n_fail++; $display("FAIL full_ignore_up: nums[3][0]=%0d full=%b, expected 0 1",
                         nums[3][0], board_full);
    end
    press(4);
    nz = 0;
    for (int r = 0; r < 4; r++) if (nums[r] !== 16'h0) nz++;
    n_checks++;
    if (nz !== 0 || curr_num !== 2'd0 || curr_digit !== 2'd0 || board_full !== 1'b0) begin
      n_fail++; $display("FAIL full_clear: nonzero_rows=%0d num=%0d digit=%0d full=%b, expected 0 0 0 0",
                         nz, curr_num, curr_digit, board_full);
    end
    n_checks++;
    if (gv_count !== base + 4) begin
      n_fail++; $display("FAIL full_no_pulse: pulses=%0d, expected 4", gv_count - base);
    end
  endtask

  task automatic test_simultaneous();
    int base;
    apply_reset();
    base = gv_count;
    btn[0] = 1'b1;
    btn[4] = 1'b1;
    cycles(10);
    btn = 5'b0;
    cycles(10);
    n_checks++;
    if (gv_count !== base + 1 || curr_num !== 2'd1) begin
      n_fail++; $display("FAIL simul_commit: pulses=%0d num=%0d, expected 1 1",
                         gv_count - base, curr_num);
    end
    n_checks++;
    if (nums[0][0] !== 4'd0) begin
      n_fail++; $display("FAIL simul_digit: nums[0][0]=%0d, expected 0", nums[0][0]);
    end
  endtask

  task automatic test_reset_mid();
    int base, nz;
    apply_reset();
    press(0);
    press(4);
    press(4);
    n_checks++;
    if (curr_num !== 2'd2 || guess_row !== 2'd1) begin
      n_fail++; $display("FAIL mid_setup: num=%0d row=%0d, expected 2 1", curr_num, guess_row);
    end
    base = gv_count;
    btn[0] = 1'b1;
    cycles(4);
    rst_n  = 1'b0;
    btn[0] = 1'b0;
    #1;
    nz = 0;
    for (int r = 0; r < 4; r++) if (nums[r] !== 16'h0) nz++;
    n_checks++;
    if (nz !== 0 || {curr_num, curr_digit, guess_row, guess_valid, board_full} !== 8'b0) begin
      n_fail++; $display("FAIL mid_async_clear: nonzero_rows=%0d num=%0d digit=%0d row=%0d, expected 0",
                         nz, curr_num, curr_digit, guess_row);
    end
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    n_checks++;
    if (nums[0][0] !== 4'd0 || gv_count !== base) begin
      n_fail++; $display("FAIL mid_no_spurious: nums[0][0]=%0d pulses=%0d, expected 0 0",
                         nums[0][0], gv_count - base);
    end
    rst_n  = 1'b0;
    btn[0] = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(4);
    n_checks++;
    if (nums[0][0] !== 4'd0) begin
      n_fail++; $display("FAIL held_early: nums[0][0]=%0d, expected 0", nums[0][0]);
    end
    cycles(6);
    n_checks++;
    if (nums[0][0] !== 4'd1) begin
      n_fail++; $display("FAIL held_press: nums[0][0]=%0d, expected 1", nums[0][0]);
    end
    btn[0] = 1'b0;
    cycles(10);
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_digit_wrap();
    test_cursor_wrap();
    test_commit();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
